// File: rtl/cv32e41p_register_file_mp_if.sv
// Bus bundle for the multi-port register file with scoreboard.
// The DUT connects through the slave modport.
interface cv32e41p_register_file_mp_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_RD     = 3,
   parameter int NUM_WR     = 2
) ();
   logic [NUM_RD-1:0][ADDR_WIDTH-1:0] raddr_i;
   logic [NUM_RD-1:0][DATA_WIDTH-1:0] rdata_o;
   logic [NUM_RD-1:0]                 rbusy_o;
   logic [NUM_WR-1:0][ADDR_WIDTH-1:0] waddr_i;
   logic [NUM_WR-1:0][DATA_WIDTH-1:0] wdata_i;
   logic [NUM_WR-1:0]                 we_i;
   logic                              alloc_req_i;
   logic [ADDR_WIDTH-1:0]             alloc_addr_i;
   logic                              alloc_gnt_o;
   logic                              flush_i;
   logic [ADDR_WIDTH:0]               busy_cnt_o;

   modport slave (
      input  raddr_i, waddr_i, wdata_i, we_i,
      input  alloc_req_i, alloc_addr_i, flush_i,
      output rdata_o, rbusy_o, alloc_gnt_o, busy_cnt_o
   );

   modport master (
      output raddr_i, waddr_i, wdata_i, we_i,
      output alloc_req_i, alloc_addr_i, flush_i,
      input  rdata_o, rbusy_o, alloc_gnt_o, busy_cnt_o
   );
endinterface

// File: rtl/cv32e41p_register_file_mp.sv
// Multi-port register file with a per-word busy scoreboard.
// Define CV32E41P_RF_BYPASS_EN to forward same-cycle write data to reads.
module cv32e41p_register_file_mp #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_RD     = 3,
   parameter int NUM_WR     = 2,
   parameter int ZERO_REG   = 1
) (
   input logic clk,
   input logic rst_n,
   input logic scan_cg_en_i,
   cv32e41p_register_file_mp_if.slave bus
);
   localparam int NW = 1 << ADDR_WIDTH;
   localparam int CW = ADDR_WIDTH + 1;

   logic [NW-1:0][DATA_WIDTH-1:0] r_mem;
   logic [NW-1:0]                 r_busy;
   logic [CW-1:0]                 r_cnt;

   logic [NW-1:0]                 w_we;
   logic [NW-1:0][DATA_WIDTH-1:0] w_wdat;
   logic [NW-1:0]                 w_busy_nxt;
   logic [CW-1:0]                 w_cnt_nxt;
   logic                          w_gnt;
   logic                          w_alloc_set;
   logic                          w_unused;

   assign w_unused = scan_cg_en_i;

   // Ascending port order lets the highest-index port win.
   always_comb begin
      w_we   = '0;
      w_wdat = '0;
      for (int w = 0; w < NUM_WR; w++) begin
         if (bus.we_i[w]) begin
            w_we[bus.waddr_i[w]]   = 1'b1;
            w_wdat[bus.waddr_i[w]] = bus.wdata_i[w];
         end
      end
      if (ZERO_REG != 0) w_we[0] = 1'b0;
   end

   assign w_gnt = rst_n & bus.alloc_req_i
                & ~r_busy[bus.alloc_addr_i] & ~bus.flush_i;

   assign w_alloc_set = w_gnt
      & ~((ZERO_REG != 0) && (bus.alloc_addr_i == '0));

   always_comb begin
      w_busy_nxt = r_busy & ~w_we;
      if (w_alloc_set) w_busy_nxt[bus.alloc_addr_i] = 1'b1;
      if (bus.flush_i) w_busy_nxt = '0;
      if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
      w_cnt_nxt = '0;
      for (int i = 0; i < NW; i++)
         w_cnt_nxt = w_cnt_nxt + CW'(w_busy_nxt[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem  <= '0;
         r_busy <= '0;
         r_cnt  <= '0;
      end else begin
         for (int i = 0; i < NW; i++)
            if (w_we[i]) r_mem[i] <= w_wdat[i];
         r_busy <= w_busy_nxt;
         r_cnt  <= w_cnt_nxt;
      end
   end

   always_comb begin
      bus.rdata_o = '0;
      bus.rbusy_o = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         bus.rdata_o[k] = r_mem[bus.raddr_i[k]];
         bus.rbusy_o[k] = r_busy[bus.raddr_i[k]];
`ifdef CV32E41P_RF_BYPASS_EN
         if (w_we[bus.raddr_i[k]]) begin
            bus.rdata_o[k] = w_wdat[bus.raddr_i[k]];
            bus.rbusy_o[k] = w_alloc_set
               && (bus.alloc_addr_i == bus.raddr_i[k]);
         end
`endif
      end
   end

   assign bus.alloc_gnt_o = w_gnt;
   assign bus.busy_cnt_o  = r_cnt;
endmodule

// File: tb/tb_cv32e41p_register_file_mp.sv
// Directed vector bench for cv32e41p_register_file_mp.
// Table of single-cycle vectors plus reset and bypass sequences.
module tb_cv32e41p_register_file_mp;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic scan_cg_en_i = 1'b0;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   cv32e41p_register_file_mp_if bus ();

   cv32e41p_register_file_mp dut (
      .clk(clk),
      .rst_n(rst_n),
      .scan_cg_en_i(scan_cg_en_i),
      .bus(bus)
   );

   typedef struct {
      logic        we0;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic        we1;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic        areq;
      logic [4:0]  aad;
      logic        fl;
      logic [4:0]  ra;
      logic [31:0] erd;
      logic        ebusy;
      logic        egnt;
      logic [5:0]  ecnt;
   } vec_t;

   vec_t v[12];

   function automatic vec_t mk(
      logic we0, logic [4:0] wa0, logic [31:0] wd0,
      logic we1, logic [4:0] wa1, logic [31:0] wd1,
      logic areq, logic [4:0] aad, logic fl,
      logic [4:0] ra, logic [31:0] erd, logic ebusy,
      logic egnt, logic [5:0] ecnt);
      vec_t r;
      r.we0 = we0; r.wa0 = wa0; r.wd0 = wd0;
      r.we1 = we1; r.wa1 = wa1; r.wd1 = wd1;
      r.areq = areq; r.aad = aad; r.fl = fl;
      r.ra = ra; r.erd = erd; r.ebusy = ebusy;
      r.egnt = egnt; r.ecnt = ecnt;
      return r;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic idle();
      bus.we_i        = '0;
      bus.alloc_req_i = 1'b0;
      bus.flush_i     = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_byp;
      logic        exp_bb;
      bus.raddr_i      = '0;
      bus.waddr_i      = '0;
      bus.wdata_i      = '0;
      bus.alloc_addr_i = 5'd3;
      idle();
      bus.alloc_req_i  = 1'b1;
      bus.raddr_i[0]   = 5'd3;

      v[0]  = mk(1, 7, 32'hAAAA0000, 1, 7, 32'h5555FFFF,
                 0, 0, 0, 7, 32'h5555FFFF, 0, 0, 0);
      v[1]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0,
                 1, 0, 0, 0, 0, 0, 1, 0);
      v[2]  = mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 3, 0, 1, 1, 1);
      v[3]  = mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 3, 0, 1, 0, 1);
      v[4]  = mk(0, 0, 0, 1, 3, 32'h33, 0, 0, 0,
                 3, 32'h33, 0, 0, 0);
      v[5]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 1, 1);
      v[6]  = mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 2, 0, 1, 1, 2);
      v[7]  = mk(0, 0, 0, 0, 0, 0, 1, 4, 0, 4, 0, 1, 1, 3);
      v[8]  = mk(0, 0, 0, 0, 0, 0, 1, 6, 1, 6, 0, 0, 0, 0);
      v[9]  = mk(1, 1, 32'h11, 0, 0, 0, 0, 0, 1,
                 1, 32'h11, 0, 0, 0);
      v[10] = mk(1, 8, 32'h88, 0, 0, 0, 1, 8, 0,
                 8, 32'h88, 1, 1, 1);
      v[11] = mk(1, 10, 32'hA0, 1, 8, 32'h99, 0, 0, 0,
                 8, 32'h99, 0, 0, 0);

      // Reset state, with an allocation request held high.
      #12;
      chk("rst_gnt", 32'(bus.alloc_gnt_o), 0);
      chk("rst_cnt", 32'(bus.busy_cnt_o), 0);
      chk("rst_rd", bus.rdata_o[0], 0);
      @(negedge clk);
      idle();
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         bus.we_i[0]      = v[i].we0;
         bus.waddr_i[0]   = v[i].wa0;
         bus.wdata_i[0]   = v[i].wd0;
         bus.we_i[1]      = v[i].we1;
         bus.waddr_i[1]   = v[i].wa1;
         bus.wdata_i[1]   = v[i].wd1;
         bus.alloc_req_i  = v[i].areq;
         bus.alloc_addr_i = v[i].aad;
         bus.flush_i      = v[i].fl;
         bus.raddr_i[0]   = v[i].ra;
         #1;
         chk($sformatf("v%0d_gnt", i), 32'(bus.alloc_gnt_o),
             32'(v[i].egnt));
         @(posedge clk);
         #1;
         idle();
         #1;
         chk($sformatf("v%0d_rd", i), bus.rdata_o[0], v[i].erd);
         chk($sformatf("v%0d_busy", i), 32'(bus.rbusy_o[0]),
             32'(v[i].ebusy));
         chk($sformatf("v%0d_cnt", i), 32'(bus.busy_cnt_o),
             32'(v[i].ecnt));
      end

      // Independent read ports.
      bus.raddr_i[1] = 5'd7;
      bus.raddr_i[2] = 5'd3;
      #1;
      chk("rd_p1", bus.rdata_o[1], 32'h5555FFFF);
      chk("rd_p2", bus.rdata_o[2], 32'h33);

      // Same-cycle write/read of a busy word.
      @(negedge clk);
      bus.we_i[0]    = 1'b1;
      bus.waddr_i[0] = 5'd9;
      bus.wdata_i[0] = 32'h1111;
      @(posedge clk);
      #1;
      idle();
      @(negedge clk);
      bus.alloc_req_i  = 1'b1;
      bus.alloc_addr_i = 5'd9;
      @(posedge clk);
      #1;
      idle();
      @(negedge clk);
      bus.we_i[0]    = 1'b1;
      bus.waddr_i[0] = 5'd9;
      bus.wdata_i[0] = 32'hCAFE;
      bus.raddr_i[0] = 5'd9;
      #1;
`ifdef CV32E41P_RF_BYPASS_EN
      exp_byp = 32'hCAFE;
      exp_bb  = 1'b0;
`else
      exp_byp = 32'h1111;
      exp_bb  = 1'b1;
`endif
      chk("byp_rd", bus.rdata_o[0], exp_byp);
      chk("byp_busy", 32'(bus.rbusy_o[0]), 32'(exp_bb));
      chk("byp_cnt", 32'(bus.busy_cnt_o), 1);
      @(posedge clk);
      #1;
      idle();
      #1;
      chk("byp_rd_after", bus.rdata_o[0], 32'hCAFE);
      chk("byp_cnt_after", 32'(bus.busy_cnt_o), 0);

      // Mid-operation reset wipes data and scoreboard.
      @(negedge clk);
      bus.we_i[0]    = 1'b1;
      bus.waddr_i[0] = 5'd5;
      bus.wdata_i[0] = 32'h1234;
      bus.raddr_i[0] = 5'd5;
      bus.alloc_req_i  = 1'b1;
      bus.alloc_addr_i = 5'd12;
      @(posedge clk);
      #1;
      idle();
      #1;
      chk("pre_rst_rd", bus.rdata_o[0], 32'h1234);
      chk("pre_rst_cnt", 32'(bus.busy_cnt_o), 1);
      @(negedge clk);
      bus.alloc_req_i  = 1'b1;
      bus.alloc_addr_i = 5'd13;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rd", bus.rdata_o[0], 0);
      chk("mid_rst_cnt", 32'(bus.busy_cnt_o), 0);
      chk("mid_rst_gnt", 32'(bus.alloc_gnt_o), 0);
      @(posedge clk);
      #1;
      chk("mid_rst_hold", bus.rdata_o[0], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
